// File: rtl/sbus_arbiter.sv
// Round-robin arbiter sharing one pulsed req/ack bus among NREQ requesters, with bus timeout.
// Optional feature: define SBUS_ARB_LOCK_EN to add m_lock_i and the locked HOLD window.
module sbus_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1048575
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      m_req_i,
    input  logic [32*NREQ-1:0]   m_addr_i,
    input  logic [32*NREQ-1:0]   m_wdata_i,
    input  logic [NREQ-1:0]      m_wr_i,
    input  logic [4*NREQ-1:0]    m_wstrb_i,
`ifdef SBUS_ARB_LOCK_EN
    input  logic [NREQ-1:0]      m_lock_i,
`endif
    output logic [NREQ-1:0]      m_ack_o,
    output logic [NREQ-1:0]      m_err_o,
    output logic [31:0]          m_rdata_o,
    output logic                 s_req_o,
    output logic [31:0]          s_addr_o,
    output logic [31:0]          s_wdata_o,
    output logic                 s_wr_o,
    output logic [3:0]           s_wstrb_o,
    input  logic                 s_ack_i,
    input  logic                 s_err_i,
    input  logic [31:0]          s_rdata_i
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD
    } state_t;

    state_t          state_q;
    logic [NREQ-1:0] pending_q;
    logic [NREQ-1:0] pending_d;
    logic [IW-1:0]   lastGrant_q;
    logic [IW-1:0]   grant_q;
    logic [TW-1:0]   timer_q;

    logic [31:0]     slotAddr_q  [NREQ];
    logic [31:0]     slotWdata_q [NREQ];
    logic [3:0]      slotWstrb_q [NREQ];
    logic [NREQ-1:0] slotWr_q;

`ifdef SBUS_ARB_LOCK_EN
    logic [NREQ-1:0] slotLock_q;
    logic            grantLock_q;
    logic [3:0]      holdCnt_q;
`endif

    logic [IW-1:0]   nextGrant_d;
    logic            rrFound_d;
    logic [IW-1:0]   issueIdx_d;
    logic            issueEn_d;
    logic            complete_d;
    logic [NREQ-1:0] grantMask_d;
    logic [NREQ-1:0] newReq_d;

    // A pulse is only accepted into an empty slot; duplicates while pending are dropped.
    assign newReq_d    = m_req_i & ~pending_q;
    assign complete_d  = (state_q == WAIT) && (s_ack_i || (timer_q == '0));
    assign grantMask_d = NREQ'(1) << grant_q;

    always_comb begin
        pending_d = pending_q | newReq_d;
        if (complete_d) begin
            pending_d = pending_d & ~grantMask_d;
        end
    end

    generate
        for (genvar i = 0; i < NREQ; i++) begin : g_slot
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    slotAddr_q[i]  <= '0;
                    slotWdata_q[i] <= '0;
                    slotWstrb_q[i] <= '0;
                    slotWr_q[i]    <= 1'b0;
`ifdef SBUS_ARB_LOCK_EN
                    slotLock_q[i]  <= 1'b0;
`endif
                end else if (newReq_d[i]) begin
                    slotAddr_q[i]  <= m_addr_i[32*i +: 32];
                    slotWdata_q[i] <= m_wdata_i[32*i +: 32];
                    slotWstrb_q[i] <= m_wstrb_i[4*i +: 4];
                    slotWr_q[i]    <= m_wr_i[i];
`ifdef SBUS_ARB_LOCK_EN
                    slotLock_q[i]  <= m_lock_i[i];
`endif
                end
            end
        end
    endgenerate

    // Round-robin: first pending slot strictly after the last grant, wrapping.
    always_comb begin
        logic [IW-1:0] cand;
        nextGrant_d = lastGrant_q;
        rrFound_d   = 1'b0;
        cand        = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(lastGrant_q) + k) % NREQ);
            if (!rrFound_d && pending_q[cand]) begin
                nextGrant_d = cand;
                rrFound_d   = 1'b1;
            end
        end
    end

    always_comb begin
        issueIdx_d = nextGrant_d;
        issueEn_d  = 1'b0;
        if (state_q == IDLE) begin
            issueEn_d = rrFound_d;
        end
`ifdef SBUS_ARB_LOCK_EN
        else if (state_q == HOLD) begin
            if (pending_q[grant_q]) begin
                issueIdx_d = grant_q;
                issueEn_d  = 1'b1;
            end else if (holdCnt_q == '0) begin
                issueEn_d = rrFound_d;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            lastGrant_q <= IW'(NREQ - 1);
            grant_q     <= '0;
            timer_q     <= '0;
            m_ack_o     <= '0;
            m_err_o     <= '0;
            m_rdata_o   <= '0;
            s_req_o     <= 1'b0;
            s_addr_o    <= '0;
            s_wdata_o   <= '0;
            s_wr_o      <= 1'b0;
            s_wstrb_o   <= '0;
`ifdef SBUS_ARB_LOCK_EN
            grantLock_q <= 1'b0;
            holdCnt_q   <= '0;
`endif
        end else begin
            s_req_o   <= 1'b0;
            m_ack_o   <= '0;
            m_err_o   <= '0;
            pending_q <= pending_d;
            case (state_q)
                IDLE, HOLD: begin
                    if (issueEn_d) begin
                        s_req_o   <= 1'b1;
                        s_addr_o  <= slotAddr_q[issueIdx_d];
                        s_wdata_o <= slotWdata_q[issueIdx_d];
                        s_wr_o    <= slotWr_q[issueIdx_d];
                        s_wstrb_o <= slotWstrb_q[issueIdx_d];
                        grant_q   <= issueIdx_d;
                        timer_q   <= TW'(TIMEOUT);
                        state_q   <= WAIT;
`ifdef SBUS_ARB_LOCK_EN
                        grantLock_q <= slotLock_q[issueIdx_d];
`endif
                    end
`ifdef SBUS_ARB_LOCK_EN
                    else if (state_q == HOLD) begin
                        if (holdCnt_q == '0) begin
                            state_q <= IDLE;
                        end else begin
                            holdCnt_q <= holdCnt_q - 4'd1;
                        end
                    end
`endif
                end
                WAIT: begin
                    // A real ack beats a timeout that expires in the same cycle.
                    if (complete_d) begin
                        m_ack_o     <= grantMask_d;
                        lastGrant_q <= grant_q;
                        state_q     <= IDLE;
                        if (s_ack_i) begin
                            m_err_o   <= grantMask_d & {NREQ{s_err_i}};
                            m_rdata_o <= s_rdata_i;
`ifdef SBUS_ARB_LOCK_EN
                            if (grantLock_q) begin
                                state_q   <= HOLD;
                                holdCnt_q <= 4'd14;
                            end
`endif
                        end else begin
                            m_err_o   <= grantMask_d;
                            m_rdata_o <= '0;
                        end
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
